// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit-serial add sequencer: digit width,
// largest legal digit, sequencer state encoding and a digit legality helper.
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  function automatic logic is_bcd(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_shifter.sv
// Parallel-load register that shifts right by one BCD digit per enabled cycle,
// inserting shift_in_i at the most-significant digit position.
module bcd_digit_shifter
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        load_i,
  input  logic [BCD_DIGIT_W*NDIG-1:0] load_val_i,
  input  logic                        shift_i,
  input  logic [BCD_DIGIT_W-1:0]      shift_in_i,
  output logic [BCD_DIGIT_W*NDIG-1:0] q_o
);

  localparam int W = BCD_DIGIT_W * NDIG;

  logic [W-1:0]             sh_q, sh_d;
  logic [W+BCD_DIGIT_W-1:0] sh_ext;

  // Widened copy keeps the shift slice legal even for a single-digit register.
  assign sh_ext = {shift_in_i, sh_q};

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = load_val_i;
    end else if (shift_i) begin
      sh_d = sh_ext[W+BCD_DIGIT_W-1:BCD_DIGIT_W];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q_o = sh_q;

endmodule

// File: rtl/bcd_add_sequencer.sv
// Feeds a serial BCD adder LSD-first and collects its sum digits plus the final
// carry digit. Optional input digit checking: define BCD_ADD_SEQ_CHECK_EN.
//
//   state | meaning
//   IDLE  | ready for operands, adder held clear
//   RUN   | streaming digit index 0..NDIGITS (NDIGITS = carry-out digit)
//   HOLD  | result presented, waiting for out_ready
module bcd_add_sequencer
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4*NDIGITS-1:0]         op_a,
  input  logic [4*NDIGITS-1:0]         op_b,
  output logic [3:0]                   dig_a,
  output logic [3:0]                   dig_b,
  output logic                         start,
  output logic                         done,
  input  logic [3:0]                   dig_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*(NDIGITS+1)-1:0]     result,
  output logic                         err
);

  localparam int OPW   = BCD_DIGIT_W * NDIGITS;
  localparam int IDX_W = $clog2(NDIGITS + 2);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OPW-1:0]   opa_q, opb_q;
  logic             accept, running, last_digit;
  logic             unused_op_hi;

  assign accept     = (state_q == IDLE) && in_valid;
  assign running    = (state_q == RUN);
  assign last_digit = (idx_q == IDX_W'(NDIGITS));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        idx_d = idx_q + 1'b1;
        if (last_digit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operands drain with zero fill, so the carry-digit slot naturally sees 0+0.
  bcd_digit_shifter #(.NDIG(NDIGITS)) u_op_a (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (accept),
    .load_val_i (op_a),
    .shift_i    (running),
    .shift_in_i (4'd0),
    .q_o        (opa_q)
  );

  bcd_digit_shifter #(.NDIG(NDIGITS)) u_op_b (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (accept),
    .load_val_i (op_b),
    .shift_i    (running),
    .shift_in_i (4'd0),
    .q_o        (opb_q)
  );

  bcd_digit_shifter #(.NDIG(NDIGITS + 1)) u_result (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (accept),
    .load_val_i ('0),
    .shift_i    (running),
    .shift_in_i (dig_sum),
    .q_o        (result)
  );

  assign unused_op_hi = ^{opa_q, opb_q};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign done      = !running;
  assign start     = running && (idx_q == '0);
  assign dig_a     = running ? opa_q[BCD_DIGIT_W-1:0] : 4'd0;
  assign dig_b     = running ? opb_q[BCD_DIGIT_W-1:0] : 4'd0;

`ifdef BCD_ADD_SEQ_CHECK_EN
  logic err_q, err_d, bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!is_bcd(op_a[BCD_DIGIT_W*i +: BCD_DIGIT_W]) ||
          !is_bcd(op_b[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = bad_digit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Self-checking bench for bcd_add_sequencer: behavioural serial adder, decimal
// reference model, per-cycle monitor and directed plus randomized operations.
module tb_bcd_add_sequencer;

  localparam int ND = 4;
  localparam int W  = 4 * ND;
  localparam int RW = 4 * (ND + 1);
`ifdef BCD_ADD_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk, rstn, in_valid, in_ready, start, done, out_valid, out_ready, err;
  logic [W-1:0]  op_a, op_b;
  logic [3:0]    dig_a, dig_b, dig_sum;
  logic [RW-1:0] result;

  int checks = 0;
  int errors = 0;
  int pcyc   = 0;
  bit stall_f  = 1'b0;
  bit rand_rdy = 1'b0;

  bcd_add_sequencer #(.NDIGITS(ND)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .dig_a     (dig_a),
    .dig_b     (dig_b),
    .start     (start),
    .done      (done),
    .dig_sum   (dig_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  // Serial BCD adder environment: combinational digit sum, registered carry.
  logic       adder_cy;
  logic [5:0] tsum;
  always_comb begin
    tsum = {2'b00, dig_a} + {2'b00, dig_b} + {5'b0, adder_cy};
    if (done)              dig_sum = 4'd0;
    else if (tsum > 6'd9)  dig_sum = 4'(tsum - 6'd10);
    else                   dig_sum = tsum[3:0];
  end
  always @(posedge clk or negedge rstn) begin
    if (!rstn)     adder_cy <= 1'b0;
    else if (done) adder_cy <= 1'b0;
    else           adder_cy <= (tsum > 6'd9);
  end

  function automatic logic [RW-1:0] bcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned va, vb, s;
    logic [RW-1:0] r;
    va = 0; vb = 0; r = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      va = va * 10 + longint'(a[4*i +: 4]);
      vb = vb * 10 + longint'(b[4*i +: 4]);
    end
    s = va + vb;
    for (int i = 0; i < ND + 1; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic bit all_bcd(input logic [W-1:0] a);
    for (int i = 0; i < ND; i++) if (a[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: expected behaviour derived from the accept event timeline.
  bit            pend = 1'b0;
  int            mon_k = 0;
  logic [W-1:0]  ea, eb;
  logic [RW-1:0] er;
  bit            ee, ev;

  always @(negedge clk) begin
    bit was_pend;
    if (!rstn) begin
      pend = 1'b0;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_done",      64'(done),      64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_start",     64'(start),     64'd0);
      chk("rst_result",    64'(result),    64'd0);
      chk("rst_err",       64'(err),       64'd0);
      chk("rst_dig",       64'({dig_a, dig_b}), 64'd0);
    end else begin
      was_pend = pend;
      if (pend && mon_k <= ND) begin
        chk("run_start", 64'(start), 64'(mon_k == 0));
        chk("run_done",  64'(done),  64'd0);
        chk("run_flags", 64'({in_ready, out_valid}), 64'd0);
        chk("run_dig_a", 64'(dig_a), (mon_k < ND) ? 64'(ea[4*mon_k +: 4]) : 64'd0);
        chk("run_dig_b", 64'(dig_b), (mon_k < ND) ? 64'(eb[4*mon_k +: 4]) : 64'd0);
        mon_k++;
      end else if (pend) begin
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready",  64'(in_ready),  64'd0);
        chk("hold_done",      64'(done),      64'd1);
        chk("hold_start_dig", 64'({start, dig_a, dig_b}), 64'd0);
        if (ev) chk("hold_result", 64'(result), 64'(er));
        chk("hold_err", 64'(err), 64'(ee));
        if (out_ready) pend = 1'b0;
      end else begin
        chk("idle_in_ready",  64'(in_ready),  64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_done",      64'(done),      64'd1);
        chk("idle_start_dig", 64'({start, dig_a, dig_b}), 64'd0);
      end
      if (!was_pend && in_valid && in_ready) begin
        pend  = 1'b1;
        mon_k = 0;
        ea    = op_a;
        eb    = op_b;
        er    = bcd_ref(op_a, op_b);
        ev    = all_bcd(op_a) && all_bcd(op_b);
        ee    = CHK && !ev;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = stall_f ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Call at posedge+1. Returns the cycle stamp just after the accept edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit has_lit,
                       input logic [RW-1:0] lit, input int stall,
                       output int acc_cyc, output logic err_seen);
    int t, n;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin errors++; $display("FAIL in_ready_timeout at %0t", $time); end
    op_a = a; op_b = b; in_valid = 1'b1;
    if (stall > 0) stall_f = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = pcyc;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin errors++; $display("FAIL out_valid_timeout at %0t", $time); end
    err_seen = err;
    if (has_lit) begin
      chk("lit_latency", 64'(n), 64'(ND + 1));
      chk("lit_result",  64'(result), 64'(lit));
    end
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      chk("stall_result",   64'(result), 64'(lit));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      stall_f = 1'b0;
    end
  endtask

  initial begin
    int c0, c1;
    logic e;
    logic [W-1:0] a, b;
    rstn = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h5678, 1, 20'h06912, 0, c0, e);
    chk("basic_err", 64'(e), 64'd0);
    do_op(16'h9999, 16'h0001, 1, 20'h10000, 0, c0, e);
    do_op(16'h9999, 16'h9999, 1, 20'h19998, 0, c0, e);
    do_op(16'h0000, 16'h0000, 1, 20'h00000, 0, c0, e);

    do_op(16'h9999, 16'h9999, 1, 20'h19998, 10, c0, e);
    do_op(16'h0500, 16'h0500, 1, 20'h01000, 0, c0, e);

    do_op(16'h4321, 16'h1111, 1, 20'h05432, 0, c0, e);
    do_op(16'h0009, 16'h0009, 1, 20'h00018, 0, c1, e);
    chk("issue_interval", 64'(c1 - c0), 64'(ND + 3));

    while (!in_ready) begin @(posedge clk); #1; end
    op_a = 16'h2222; op_b = 16'h3333; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_done",     64'(done),     64'd1);
    chk("midrst_result",   64'(result),   64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0001, 16'h0001, 1, 20'h00002, 0, c0, e);

    do_op(16'h12A4, 16'h0000, 0, '0, 0, c0, e);
    chk("digit_err", 64'(e), 64'(CHK));
    do_op(16'h0011, 16'h0022, 1, 20'h00033, 0, c0, e);
    chk("digit_err_clear", 64'(e), 64'd0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = rand_bcd();
      b = rand_bcd();
      if ($urandom_range(0, 9) == 0) a[4*$urandom_range(0, ND-1) +: 4] = 4'($urandom_range(10, 15));
      do_op(a, b, 0, '0, 0, c0, e);
    end
    rand_rdy = 1'b0;
    for (int t = 0; t < 100 && !in_ready; t++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_add_sequencer.md
# bcd_add_sequencer

Digit-serial sequencer that surrounds the serial BCD adder datapath. It accepts two packed N-digit BCD operands over a valid/ready handshake and streams digit pairs to the adder, least-significant digit first. It collects the returned sum digits, appends the final carry digit, and presents the packed (N+1)-digit BCD result over a second valid/ready handshake. It is both the upstream feeder and the downstream collector of the serial adder.

## Interface
- `NDIGITS`, default 4: operand width in BCD digits; legal range 1..16.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer can accept operands.
- `op_a`, `op_b`  in  4*NDIGITS each  packed BCD operands; digit 0 is in [3:0].
- `dig_a`, `dig_b`  out  4 each  current digit pair to the adder.
- `start`  out  1  high on the cycle that digit 0 is presented.
- `done`  out  1  adder clear; forces adder sum to 0 and clears its carry.
- `dig_sum`  in  4  adder sum digit, combinational from `dig_a`/`dig_b`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  4*(NDIGITS+1)  packed BCD sum; the top digit is 0 or 1.
- `err`  out  1  input digit error flag (see Configuration).

## Operation
- States: IDLE, RUN, HOLD.
- **IDLE:**
  - `in_ready`=1 and `done`=1.
  - On `in_valid`&`in_ready`: latch `op_a` and `op_b`, set the digit index to 0, and go to RUN.
- **RUN:** lasts NDIGITS+1 cycles, index 0..NDIGITS.
  - For index < NDIGITS: drive `dig_a`/`dig_b` with the latched digit at that index.
  - For index = NDIGITS (carry digit): drive `dig_a`=`dig_b`=0.
  - `done`=0.
  - `start`=1 only at index 0.
  - Each edge shifts `dig_sum` into `result[4*(NDIGITS+1)-1 -: 4]`, with the remaining result shifting right by 4.
  - After index NDIGITS, go to HOLD.
- **HOLD:**
  - `out_valid`=1, `done`=1, `in_ready`=0.
  - `result` is stable until the handshake.
  - On `out_ready`, go to IDLE.
- Outputs are combinational from state only: `done` = (state != RUN), `in_ready` = IDLE, `out_valid` = HOLD.
- `dig_a`/`dig_b` are 0 outside RUN.
- Operand digits shift right by 4 per RUN cycle; no wide multiplexer indexing.
- Arithmetic is performed solely by the adder. The sequencer performs no correction.
- The final carry arrives as digit NDIGITS because the adder adds its carry into 0+0.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `start`=0, `done`=1.
  - `dig_a`=`dig_b`=0, `result`=0, `err`=0.
  - The index and operand registers are 0.
- Reset mid-RUN or mid-HOLD: return immediately to IDLE. The partial result is discarded. `done`=1 clears the adder carry.
- `in_valid` during RUN or HOLD is ignored, because `in_ready`=0.

## Timing
- Call the accept edge E0.
- Edges E1..E(NDIGITS+1) capture sum digits 0..NDIGITS.
- `out_valid` rises in the cycle after E(NDIGITS+1), i.e. NDIGITS+1 cycles after E0.
- The HOLD→IDLE edge is the output handshake edge. `in_ready` reasserts in the following cycle; there is no bypass.
- Minimum issue interval is NDIGITS+3 cycles with `out_ready` held high.
- `out_ready` low stalls HOLD indefinitely. `result` and `err` stay stable throughout the stall.

## Configuration
- Macro: `BCD_ADD_SEQ_CHECK_EN`.
- **Defined:**
  - At the accept edge, `err` is latched high if any digit of `op_a` or `op_b` is greater than 9.
  - `err` is valid while `out_valid` is high.
  - `err` clears on the next accept or on reset.
  - The addition still runs, and `result` is then unspecified.
- **Undefined:** `err` is tied to 0 and no checking logic exists.

## Structure
- Package `bcd_pkg` holds:
  - `BCD_DIGIT_W` = 4 and `BCD_MAX` = 4'd9.
  - The state typedef (IDLE, RUN, HOLD).
  - Function `is_bcd(digit)`.
- Sub-module `bcd_digit_shifter`, parameterized by digit count. It provides a parallel-load, 4-bit-per-shift register.
  - Instantiated three times: once for each operand and once for the result collector.

## Test plan
- **Basic sum:** NDIGITS=4, `op_a`=16'h1234, `op_b`=16'h5678 → `result`=20'h06912, `err`=0, `out_valid` 5 cycles after accept, `start` high exactly one cycle.
- **Full carry ripple:** 16'h9999 + 16'h0001 → `result`=20'h10000.
- **Maximum and zero:** 16'h9999 + 16'h9999 → 20'h19998; 0 + 0 → 20'h00000.
- **Stall and back-to-back:** hold `out_ready` low for 10 cycles → `result` stable, `in_ready`=0. Release, then issue immediately 16'h0500 + 16'h0500 → 20'h01000. The second result must not be corrupted by carry left from the first.
- **Reset mid-operation:** assert `rstn`=0 at RUN index 2 → next cycle `in_ready`=1, `done`=1, `result`=0. A following 16'h0001 + 16'h0001 gives 20'h00002.
- **Digit error, macro defined:** `op_a`=16'h12A4 → `err`=1 with `out_valid`; the next valid operation gives `err`=0. With the macro undefined, `err` stays 0.
